// File: rtl/frontpanel_spi_device.sv
// -----------------------------------------------------------------------------
// frontpanel_spi_device
// Device side of the write-only front panel SPI link. Resynchronises SCK, MOSI
// and CS_N into clk, deserialises mode-0 MSB-first bytes and reports each byte
// with its index in the chip-select frame, plus frame open/close pulses.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   spi_sck       SPI clock from host (async)
//   spi_mosi      SPI data from host (async)
//   spi_cs_n      active-low chip select from host (async)
//   frame_start   one-cycle pulse when a frame opens
//   rx_valid      one-cycle pulse when rx_data/rx_index update
//   rx_data       last completed byte
//   rx_index      position of rx_data within the frame
//   frame_end     one-cycle pulse when a frame closes
//   frame_len     complete bytes accepted in the closed frame (held)
//   frame_err     closed frame ended mid-byte or overflowed (held)
//   busy          high while a frame is open
// -----------------------------------------------------------------------------
module frontpanel_spi_device #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned MAX_FRAME_BYTES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   input  logic       spi_cs_n,
   output logic       frame_start,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic [7:0] rx_index,
   output logic       frame_end,
   output logic [7:0] frame_len,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned DW      = 8;
   localparam int unsigned BCW     = 3;
   localparam int unsigned FLUSH_W = 3;
   // Cycles for the reset values to drain out of the synchronisers and edge register.
   localparam int unsigned FLUSH   = SYNC_STAGES + 1;

   typedef enum logic [1:0] {
      S_DISARMED = 2'd0,
      S_IDLE     = 2'd1,
      S_ACTIVE   = 2'd2
   } state_t;

   // Pin synchronisers plus one edge-detect register per signal
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sck_d;
   logic                   r_mosi_d;
   logic                   r_cs_d;
   logic [FLUSH_W-1:0]     r_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_sck_d     <= 1'b0;
         r_mosi_d    <= 1'b0;
         r_cs_d      <= 1'b1;
         r_flush     <= '0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
         r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
         r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
         if (r_flush != FLUSH_W'(FLUSH)) r_flush <= r_flush + FLUSH_W'(1);
      end
   end

   logic w_sck_rise;
   logic w_cs_fall;
   logic w_cs_rise;
   logic w_cs_high;
   logic w_flushed;

   assign w_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
   assign w_cs_fall  = ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;
   assign w_cs_rise  = r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
   assign w_cs_high  = r_cs_sync[SYNC_STAGES-1] & r_cs_d;
   assign w_flushed  = (r_flush == FLUSH_W'(FLUSH));

   // FSM and datapath registers
   state_t          r_state;
   logic [BCW-1:0]  r_bit_cnt;
   logic [DW-1:0]   r_byte_cnt;
   logic            r_ovf;
   logic [DW-1:0]   r_shift;
   logic            r_frame_start;
   logic            r_rx_valid;
   logic [DW-1:0]   r_rx_data;
   logic [DW-1:0]   r_rx_index;
   logic            r_frame_end;
   logic [DW-1:0]   r_frame_len;
   logic            r_frame_err;
   logic            r_busy;

   state_t          w_nxt_state;
   logic [BCW-1:0]  w_nxt_bit_cnt;
   logic [DW-1:0]   w_nxt_byte_cnt;
   logic            w_nxt_ovf;
   logic [DW-1:0]   w_nxt_shift;
   logic            w_nxt_frame_start;
   logic            w_nxt_rx_valid;
   logic [DW-1:0]   w_nxt_rx_data;
   logic [DW-1:0]   w_nxt_rx_index;
   logic            w_nxt_frame_end;
   logic [DW-1:0]   w_nxt_frame_len;
   logic            w_nxt_frame_err;
   logic            w_nxt_busy;
   logic [DW-1:0]   w_byte;

   assign w_byte = {r_shift[DW-2:0], r_mosi_d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_DISARMED;
         r_bit_cnt     <= '0;
         r_byte_cnt    <= '0;
         r_ovf         <= 1'b0;
         r_shift       <= '0;
         r_frame_start <= 1'b0;
         r_rx_valid    <= 1'b0;
         r_rx_data     <= '0;
         r_rx_index    <= '0;
         r_frame_end   <= 1'b0;
         r_frame_len   <= '0;
         r_frame_err   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_bit_cnt     <= w_nxt_bit_cnt;
         r_byte_cnt    <= w_nxt_byte_cnt;
         r_ovf         <= w_nxt_ovf;
         r_shift       <= w_nxt_shift;
         r_frame_start <= w_nxt_frame_start;
         r_rx_valid    <= w_nxt_rx_valid;
         r_rx_data     <= w_nxt_rx_data;
         r_rx_index    <= w_nxt_rx_index;
         r_frame_end   <= w_nxt_frame_end;
         r_frame_len   <= w_nxt_frame_len;
         r_frame_err   <= w_nxt_frame_err;
         r_busy        <= w_nxt_busy;
      end
   end

   // Next-state and next-output logic; sck edges coinciding with a CS_N edge are dropped
   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_bit_cnt     = r_bit_cnt;
      w_nxt_byte_cnt    = r_byte_cnt;
      w_nxt_ovf         = r_ovf;
      w_nxt_shift       = r_shift;
      w_nxt_frame_start = 1'b0;
      w_nxt_rx_valid    = 1'b0;
      w_nxt_rx_data     = r_rx_data;
      w_nxt_rx_index    = r_rx_index;
      w_nxt_frame_end   = 1'b0;
      w_nxt_frame_len   = r_frame_len;
      w_nxt_frame_err   = r_frame_err;
      w_nxt_busy        = r_busy;

      case (r_state)
         S_DISARMED: begin
            // Wait for reset values to flush so a frame live at reset release is skipped
            if (w_flushed && w_cs_high) w_nxt_state = S_IDLE;
         end
         S_IDLE: begin
            if (w_cs_fall) begin
               w_nxt_state       = S_ACTIVE;
               w_nxt_frame_start = 1'b1;
               w_nxt_busy        = 1'b1;
               w_nxt_bit_cnt     = '0;
               w_nxt_byte_cnt    = '0;
               w_nxt_ovf         = 1'b0;
               w_nxt_shift       = '0;
            end
         end
         S_ACTIVE: begin
            if (w_cs_rise) begin
               w_nxt_state     = S_IDLE;
               w_nxt_frame_end = 1'b1;
               w_nxt_frame_len = r_byte_cnt;
               w_nxt_frame_err = (r_bit_cnt != '0) | r_ovf;
               w_nxt_busy      = 1'b0;
            end else if (w_sck_rise) begin
               w_nxt_shift   = w_byte;
               w_nxt_bit_cnt = r_bit_cnt + BCW'(1);
               if (r_bit_cnt == BCW'(7)) begin
                  if (r_byte_cnt < DW'(MAX_FRAME_BYTES)) begin
                     w_nxt_rx_valid = 1'b1;
                     w_nxt_rx_data  = w_byte;
                     w_nxt_rx_index = r_byte_cnt;
                     w_nxt_byte_cnt = r_byte_cnt + DW'(1);
                  end else begin
                     w_nxt_ovf = 1'b1;
                  end
               end
            end
         end
         default: w_nxt_state = S_DISARMED;
      endcase
   end

   assign frame_start = r_frame_start;
   assign rx_valid    = r_rx_valid;
   assign rx_data     = r_rx_data;
   assign rx_index    = r_rx_index;
   assign frame_end   = r_frame_end;
   assign frame_len   = r_frame_len;
   assign frame_err   = r_frame_err;
   assign busy        = r_busy;

endmodule

// File: tb/tb_frontpanel_spi_device.sv
// -----------------------------------------------------------------------------
// tb_frontpanel_spi_device
// Drives SPI frames at the pins and compares the reported bytes and frame
// results against a frame-level model of what the host sent.
// -----------------------------------------------------------------------------
module tb_frontpanel_spi_device;

   localparam int unsigned SS   = 2;
   localparam int unsigned MAXB = 4;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       spi_sck  = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       frame_start;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] rx_index;
   logic       frame_end;
   logic [7:0] frame_len;
   logic       frame_err;
   logic       busy;

   frontpanel_spi_device #(
      .SYNC_STAGES     (SS),
      .MAX_FRAME_BYTES (MAXB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_cs_n    (spi_cs_n),
      .frame_start (frame_start),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_index    (rx_index),
      .frame_end   (frame_end),
      .frame_len   (frame_len),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int          n_checks    = 0;
   int          n_fail      = 0;
   int          n_start_obs = 0;
   int          n_start_exp = 0;
   logic [15:0] obs_rx[$];
   logic [15:0] exp_rx[$];
   logic [8:0]  obs_end[$];
   logic [8:0]  exp_end[$];
   logic [7:0]  fb[8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Event monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_start) begin
            n_start_obs++;
            check("busy_at_start", 32'(busy), 32'd1);
         end
         if (rx_valid) obs_rx.push_back({rx_index, rx_data});
         if (frame_end) begin
            obs_end.push_back({frame_len, frame_err});
            check("busy_at_end", 32'(busy), 32'd0);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      spi_mosi = b;
      wait_cyc(4);
      spi_sck = 1'b1;
      wait_cyc(4);
      spi_sck = 1'b0;
   endtask

   // Expected results of one frame: bytes beyond MAXB are dropped, partial or excess marks an error
   task automatic model_frame(input int nb, input int extra);
      int sent;
      sent = (nb > int'(MAXB)) ? int'(MAXB) : nb;
      n_start_exp++;
      for (int i = 0; i < sent; i++) exp_rx.push_back({8'(i), fb[i]});
      exp_end.push_back({8'(sent), (extra != 0) || (nb > int'(MAXB))});
   endtask

   // One complete frame of nb bytes from fb plus extra random bits;
   // coincide puts one more SCK rise in the same instant as CS_N rising
   task automatic run_frame(input int nb, input int extra, input bit coincide, input int gap);
      model_frame(nb, extra);
      spi_cs_n = 1'b0;
      wait_cyc(4);
      for (int i = 0; i < nb; i++)
         for (int b = 7; b >= 0; b--) send_bit(fb[i][b]);
      for (int i = 0; i < extra; i++) send_bit(1'($urandom));
      if (coincide) begin
         spi_mosi = 1'($urandom);
         wait_cyc(4);
         spi_sck  = 1'b1;
         spi_cs_n = 1'b1;
         wait_cyc(4);
         spi_sck  = 1'b0;
      end else begin
         wait_cyc(4);
         spi_cs_n = 1'b1;
      end
      wait_cyc(gap);
   endtask

   task automatic verify(input string tag);
      int n;
      wait_cyc(12);
      check({tag, "_starts"}, 32'(n_start_obs), 32'(n_start_exp));
      check({tag, "_rx_count"}, 32'(obs_rx.size()), 32'(exp_rx.size()));
      n = (obs_rx.size() < exp_rx.size()) ? obs_rx.size() : exp_rx.size();
      for (int i = 0; i < n; i++) check({tag, "_rx_idx_data"}, 32'(obs_rx[i]), 32'(exp_rx[i]));
      check({tag, "_end_count"}, 32'(obs_end.size()), 32'(exp_end.size()));
      n = (obs_end.size() < exp_end.size()) ? obs_end.size() : exp_end.size();
      for (int i = 0; i < n; i++) check({tag, "_len_err"}, 32'(obs_end[i]), 32'(exp_end[i]));
      obs_rx.delete();
      exp_rx.delete();
      obs_end.delete();
      exp_end.delete();
      n_start_obs = 0;
      n_start_exp = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      check({tag, "_rx_valid"},    32'(rx_valid),    32'd0);
      check({tag, "_rx_data"},     32'(rx_data),     32'd0);
      check({tag, "_rx_index"},    32'(rx_index),    32'd0);
      check({tag, "_frame_end"},   32'(frame_end),   32'd0);
      check({tag, "_frame_len"},   32'(frame_len),   32'd0);
      check({tag, "_frame_err"},   32'(frame_err),   32'd0);
      check({tag, "_busy"},        32'(busy),        32'd0);
   endtask

   initial begin
      wait_cyc(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      wait_cyc(10);

      // Basic two-byte frame
      fb[0] = 8'hA5; fb[1] = 8'h3C;
      run_frame(2, 0, 1'b0, 6);
      verify("basic");

      // Partial trailing byte
      fb[0] = 8'h81;
      run_frame(1, 3, 1'b0, 6);
      verify("partial");

      // Overflow past MAXB
      for (int i = 0; i < 6; i++) fb[i] = 8'(i);
      run_frame(6, 0, 1'b0, 6);
      verify("overflow");

      // Reset after 12 bits with CS_N held low: only the first byte was ever reported
      fb[0] = 8'(($urandom));
      n_start_exp++;
      exp_rx.push_back({8'd0, fb[0]});
      spi_cs_n = 1'b0;
      wait_cyc(4);
      for (int b = 7; b >= 0; b--) send_bit(fb[0][b]);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom));
      rst_n = 1'b0;
      wait_cyc(2);
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) send_bit(1'($urandom));
      wait_cyc(4);
      spi_cs_n = 1'b1;
      wait_cyc(6);
      verify("midreset");
      fb[0] = 8'h7E;
      run_frame(1, 0, 1'b0, 6);
      verify("after_reset");

      // Back-to-back frames with minimum CS_N high time
      fb[0] = 8'hC3; fb[1] = 8'h5A;
      run_frame(2, 0, 1'b0, 3);
      fb[0] = 8'h0F;
      run_frame(1, 0, 1'b0, 6);
      verify("back_to_back");

      // SCK rise in the same cycle as CS_N rise
      fb[0] = 8'h96;
      run_frame(1, 0, 1'b1, 6);
      verify("coincident");

      // Randomised frames
      for (int f = 0; f < 12; f++) begin
         int nb;
         int extra;
         bit co;
         nb    = int'($urandom_range(0, 6));
         extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
         co    = (extra == 0) && ($urandom_range(0, 2) == 0);
         for (int i = 0; i < nb; i++) fb[i] = 8'($urandom);
         run_frame(nb, extra, co, int'($urandom_range(3, 8)));
         verify("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frontpanel_spi_device.md
# frontpanel_spi_device

SPI device-side receiver for the front panel FPGA, terminating the write-only SPI link driven by the mainboard management subsystem (SCK, MOSI, CS_N; no MISO). It synchronizes the three pins into the local clock domain, deserializes mode-0, MSB-first bytes, and presents each byte with its index within the chip-select frame. Frame boundaries are reported as single-cycle pulses so the downstream front panel register decoder can treat each CS_N assertion as one command.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of the pin synchronizers; legal range 2..4.
- MAX_FRAME_BYTES, 255, bytes accepted per frame. Further bytes are dropped and flagged. Must fit in 8 bits.

Ports:
- clk  in  1  local system clock; must be ≥ 8× the SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock from host, asynchronous to clk.
- spi_mosi  in  1  SPI data from host, asynchronous.
- spi_cs_n  in  1  active-low chip select from host, asynchronous.
- frame_start  out  1  one-cycle pulse when a frame opens.
- rx_valid  out  1  one-cycle pulse when rx_data/rx_index are updated.
- rx_data  out  8  last completed byte.
- rx_index  out  8  zero-based position of rx_data in the current frame.
- frame_end  out  1  one-cycle pulse when a frame closes.
- frame_len  out  8  number of complete bytes accepted in the closed frame. Valid with frame_end and held afterwards.
- frame_err  out  1  valid with frame_end and held afterwards. Set if the frame ended mid-byte or exceeded MAX_FRAME_BYTES.
- busy  out  1  high while a frame is open.

## Operation
- Synchronizers: sck, mosi and cs_n each pass through SYNC_STAGES flops.
  - sck and mosi reset to 0. cs_n resets to 1 (deasserted).
  - One extra register per signal provides edge detection. mosi is delayed to stay aligned with sck.
- States: DISARMED, IDLE, ACTIVE.
  - DISARMED is entered on reset. It moves to IDLE once synced cs_n has been seen high. A frame already in progress at reset release is therefore ignored.
  - IDLE moves to ACTIVE on a synced cs_n falling edge. On that transition: pulse frame_start, set busy, clear bit counter, byte counter and overflow flag.
  - ACTIVE moves to IDLE on a synced cs_n rising edge. On that transition: pulse frame_end, latch frame_len = byte counter, latch frame_err = (bit counter ≠ 0) | overflow, clear busy.
- Bit capture in ACTIVE:
  - Each synced sck rising edge shifts the aligned mosi into the LSB of the shift register (MSB first).
  - sck falling edges are ignored (mode 0).
  - The bit counter is 3 bits. When it wraps 7→0, the completed byte is handled as follows:
    - byte counter < MAX_FRAME_BYTES: rx_data = byte, rx_index = byte counter, pulse rx_valid, increment byte counter.
    - otherwise: no rx_valid, set overflow, byte counter saturates.
- Simultaneous events:
  - sck rising and cs_n rising in the same cycle: close the frame; the sck edge is discarded.
  - sck rising edges in IDLE or DISARMED: ignored.
  - cs_n falling and sck rising in the same cycle: open the frame; the sck edge is discarded.
- Reset values: frame_start 0, rx_valid 0, rx_data 0, rx_index 0, frame_end 0, frame_len 0, frame_err 0, busy 0.
- Asynchronous reset mid-frame aborts the frame with no frame_end pulse. The block re-enters DISARMED.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 clk cycles from a pin edge to the corresponding internal edge strobe.
- rx_valid asserts SYNC_STAGES+2 cycles after the 8th SCK rising edge at the pin. rx_data and rx_index update in that same cycle and hold until the next rx_valid.
- frame_start and frame_end each assert SYNC_STAGES+2 cycles after the corresponding CS_N pin edge.
- Minimum SCK high time and low time: 3 clk cycles each. Minimum CS_N high time between frames: 3 clk cycles.
- No backpressure: the consumer must accept rx_valid in the cycle it asserts.
- All outputs are registered.

## Test plan
- Basic frame: CS_N low, send 0xA5 then 0x3C, CS_N high. Expect:
  - frame_start, then rx_valid with (0xA5, index 0) and (0x3C, index 1);
  - frame_end with frame_len=2, frame_err=0.
- Partial byte: send 0x81 plus 3 extra bits, then raise CS_N. Expect one rx_valid (0x81), frame_len=1, frame_err=1.
- Overflow with MAX_FRAME_BYTES=4: send 6 bytes 0x00..0x05. Expect rx_valid for indices 0..3 only, frame_len=4, frame_err=1.
- Reset mid-frame: pulse rst_n low after 12 bits with CS_N still low, then send 2 more bytes and raise CS_N. Expect no rx_valid and no frame_end. Then open a fresh frame with 0x7E; expect rx_valid 0x7E, index 0.
- Back-to-back frames at minimum CS_N high time (3 cycles) with SCK at clk/8. Expect two frame_start/frame_end pairs, each with correct frame_len, and no bits leaking between frames.
- Same-cycle edges: SCK rising coincident with CS_N rising after 8 bits. Expect the byte delivered, the extra edge discarded, frame_len=1, frame_err=0.
